// File: rtl/i_ref_sweep_ctrl.sv
// Reference-current sweep controller.
// Steps i_ref upward from I_START in STEP increments. At each point it waits
// SETTLE_CYCLES cycles, then raises a one-cycle ready pulse so the code can be
// sampled. When the loop monitor reports instability, the last-stable code is
// captured from i_ref_max and backed off by BACKOFF to form the operating point.
// If full scale is reached without instability, the sweep saturates and stops
// at the last code.
//
// Handshake: the controller has no back-pressure. ready is a one-cycle strobe
// that marks "i_ref is settled this cycle". done is a level that stays high
// until enable is dropped. enable is a level request. Dropping it during a
// sweep aborts the sweep, and dropping it while done is high acknowledges
// the result.
module i_ref_sweep_ctrl #(
  parameter int BUS_WIDTH     = 10,
  parameter int I_START       = 0,
  parameter int STEP          = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int BACKOFF       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 went_unstable,
  input  logic [BUS_WIDTH-1:0] i_ref_max,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 ready,
  output logic [BUS_WIDTH-1:0] i_ref_op,
  output logic                 busy,
  output logic                 done,
  output logic                 sat,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    SAMPLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST     = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] START_CODE   = BUS_WIDTH'(I_START);
  localparam logic [BUS_WIDTH-1:0] STEP_CODE    = BUS_WIDTH'(STEP);
  localparam logic [BUS_WIDTH-1:0] BACKOFF_CODE = BUS_WIDTH'(BACKOFF);
  localparam logic [BUS_WIDTH:0]   FULL_SCALE   = {1'b0, {BUS_WIDTH{1'b1}}};

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BUS_WIDTH:0]   next_code_wide;
  logic                 at_full_scale;
  logic                 backoff_ok;
  logic [BUS_WIDTH-1:0] capture_code;

  // The next code is formed one bit wider, so a step past full scale is detected
  // rather than wrapped.
  assign next_code_wide = {1'b0, i_ref} + {1'b0, STEP_CODE};
  assign at_full_scale  = (next_code_wide > FULL_SCALE);

  // The back-off is clamped at zero. The comparison is 32 bits wide, so a
  // BACKOFF larger than the bus still compares correctly.
  assign backoff_ok   = (32'(i_ref_max) >= 32'(BACKOFF));
  assign capture_code = backoff_ok ? (i_ref_max - BACKOFF_CODE) : '0;

  assign state_dbg = state_q;

  // Sweep FSM. Every output is registered here. Abort has the highest
  // priority, then instability, then the normal settle/sample stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      i_ref    <= START_CODE;
      ready    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat      <= 1'b0;
      i_ref_op <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            i_ref   <= START_CODE;
            cnt_q   <= '0;
            done    <= 1'b0;
            sat     <= 1'b0;
            busy    <= 1'b1;
            ready   <= 1'b0;
            state_q <= SETTLE;
          end
        end
        SETTLE, SAMPLE: begin
          ready <= 1'b0;
          if (!enable) begin
            i_ref   <= START_CODE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else if (went_unstable) begin
            state_q <= CAPTURE;
          end else if (state_q == SETTLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              ready   <= 1'b1;
              state_q <= SAMPLE;
            end
          end else if (at_full_scale) begin
            sat      <= 1'b1;
            i_ref_op <= i_ref;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= DONE;
          end else begin
            i_ref   <= next_code_wide[BUS_WIDTH-1:0];
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        CAPTURE: begin
          i_ref_op <= capture_code;
          i_ref    <= capture_code;
          busy     <= 1'b0;
          done     <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (!enable) begin
            done    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
